// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding and default sizing for the serial master port
package bus_pkg;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_ACK_TIMEOUT = 8;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        ADDR,
        WAIT_ACK,
        WDATA,
        WAIT_WACK,
        RDATA,
        HOLD,
        DONE
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/master_port_counter.sv
// rtl/master_port_counter.sv - free-running bit/timeout counter with synchronous clear
module master_port_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         incr,
    output logic [W-1:0] count
);

    // clear has priority so a state change always restarts counting from zero
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/master_port.sv
// rtl/master_port.sv - serial bus master: arbitration, address/data shift-out, read shift-in
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              M_EXECUTE,
    input  logic              M_RW,
    input  logic [ADDR_W-1:0] M_ADDR,
    input  logic [DATA_W-1:0] M_DIN,
    output logic              M_BUSY,
    output logic              M_DVALID,
    output logic [DATA_W-1:0] M_DOUT,
    output logic              M_DONE,
    output logic              M_ERR,
    output logic              M_REQ,
    input  logic              M_GRANT,
    output logic              B_UTIL,
    output logic              B_RW,
    output logic              B_BUS_OUT,
    input  logic              B_BUS_IN,
    input  logic              B_ACK,
    input  logic              B_SPLIT
);

    localparam int CNT_W = $clog2(max3(ADDR_W, DATA_W, ACK_TIMEOUT)) + 1;
    localparam int RD_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt;
    logic                cnt_clr;
    logic [ADDR_W-1:0]   addr_q, addr_sh;
    logic [DATA_W-1:0]   data_q, data_sh;
    logic                rw_q;
    logic                err_q;
    logic [DATA_W-1:0]   shreg, rd_next, dout_q;
    logic [RD_W-1:0]     rd_idx;
    logic                sample, rd_last, timeout;

    assign cnt_clr = RST || (state_next != state);
    assign addr_sh = addr_q >> cnt;
    assign data_sh = data_q >> cnt;
    assign rd_last = (rd_idx == RD_W'(DATA_W - 1));
    assign M_DOUT  = dout_q;
    assign M_ERR   = err_q;

    master_port_counter #(.W(CNT_W)) u_cnt (
        .clk   (CLK),
        .rst   (cnt_clr),
        .incr  (state != IDLE),
        .count (cnt)
    );

    // state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state and bus/handshake outputs; the read bit index lives outside the
    // counter so a split (which changes state and clears the counter) loses nothing
    always_comb begin
        state_next = state;
        sample     = 1'b0;
        timeout    = 1'b0;
        B_BUS_OUT  = 1'b0;
        rd_next    = shreg;
        rd_next[rd_idx] = B_BUS_IN;
        case (state)
            IDLE:      if (M_EXECUTE) state_next = REQ;
            REQ:       if (M_GRANT) state_next = ADDR;
            ADDR: begin
                B_BUS_OUT = addr_sh[0];
                if (cnt == CNT_W'(ADDR_W - 1)) state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (B_ACK) begin
                    state_next = rw_q ? WDATA : RDATA;
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_next = DONE;
                    timeout    = 1'b1;
                end
            end
            WDATA: begin
                B_BUS_OUT = data_sh[0];
                if (cnt == CNT_W'(DATA_W - 1)) state_next = WAIT_WACK;
            end
            WAIT_WACK: begin
                if (B_ACK) begin
                    state_next = DONE;
                end else if (cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    state_next = DONE;
                    timeout    = 1'b1;
                end
            end
            RDATA: begin
                if (B_SPLIT) begin
                    state_next = HOLD;
                end else begin
                    sample = 1'b1;
                    if (rd_last) state_next = DONE;
                end
            end
            HOLD:      if (!B_SPLIT) state_next = RDATA;
            DONE:      state_next = IDLE;
            default:   state_next = IDLE;
        endcase

        M_BUSY   = (state != IDLE);
        M_REQ    = (state != IDLE) && (state != DONE);
        B_UTIL   = (state != IDLE) && (state != REQ) && (state != DONE);
        B_RW     = B_UTIL && rw_q;
        M_DONE   = (state == DONE);
        M_DVALID = (state == DONE) && !rw_q && !err_q;
    end

    // request latches, read shift register, result and error flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            addr_q <= '0;
            data_q <= '0;
            rw_q   <= 1'b0;
            err_q  <= 1'b0;
            shreg  <= '0;
            rd_idx <= '0;
            dout_q <= '0;
        end else begin
            if (state == IDLE && M_EXECUTE) begin
                addr_q <= M_ADDR;
                data_q <= M_DIN;
                rw_q   <= M_RW;
                err_q  <= 1'b0;
                shreg  <= '0;
                rd_idx <= '0;
            end
            if (timeout) begin
                err_q <= 1'b1;
            end
            if (sample) begin
                shreg  <= rd_next;
                rd_idx <= rd_idx + 1'b1;
                if (rd_last) dout_q <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_master_port.sv
// tb/tb_master_port.sv - directed scoreboard bench for master_port
module tb_master_port;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        M_EXECUTE = 1'b0;
    logic        M_RW = 1'b0;
    logic [15:0] M_ADDR = '0;
    logic [7:0]  M_DIN = '0;
    logic        M_BUSY, M_DVALID, M_DONE, M_ERR, M_REQ;
    logic [7:0]  M_DOUT;
    logic        M_GRANT = 1'b0;
    logic        B_UTIL, B_RW, B_BUS_OUT;
    logic        B_BUS_IN = 1'b0;
    logic        B_ACK = 1'b0;
    logic        B_SPLIT = 1'b0;

    int tests = 0;
    int fails = 0;

    logic       bit_q[$];
    logic [7:0] rd_q[$];
    logic [7:0] last_good;

    master_port dut (
        .CLK       (CLK),
        .RST       (RST),
        .M_EXECUTE (M_EXECUTE),
        .M_RW      (M_RW),
        .M_ADDR    (M_ADDR),
        .M_DIN     (M_DIN),
        .M_BUSY    (M_BUSY),
        .M_DVALID  (M_DVALID),
        .M_DOUT    (M_DOUT),
        .M_DONE    (M_DONE),
        .M_ERR     (M_ERR),
        .M_REQ     (M_REQ),
        .M_GRANT   (M_GRANT),
        .B_UTIL    (B_UTIL),
        .B_RW      (B_RW),
        .B_BUS_OUT (B_BUS_OUT),
        .B_BUS_IN  (B_BUS_IN),
        .B_ACK     (B_ACK),
        .B_SPLIT   (B_SPLIT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   M_BUSY,    0);
        check({tag, "_req"},    M_REQ,     0);
        check({tag, "_util"},   B_UTIL,    0);
        check({tag, "_brw"},    B_RW,      0);
        check({tag, "_busout"}, B_BUS_OUT, 0);
        check({tag, "_done"},   M_DONE,    0);
        check({tag, "_dvalid"}, M_DVALID,  0);
        check({tag, "_dout"},   M_DOUT,    0);
        check({tag, "_err"},    M_ERR,     0);
    endtask

    task automatic push_frame(input logic rw, input logic [15:0] addr, input logic [7:0] din);
        for (int i = 0; i < 16; i++) bit_q.push_back(addr[i]);
        if (rw) for (int i = 0; i < 8; i++) bit_q.push_back(din[i]);
    endtask

    task automatic shift_out(input string tag, input logic rw, input int nbits);
        for (int k = 0; k < nbits; k++) begin
            check({tag, "_util"}, B_UTIL, 1);
            check({tag, "_brw"}, B_RW, {31'd0, rw});
            check({tag, "_bit"}, B_BUS_OUT, {31'd0, bit_q.pop_front()});
            tick();
        end
    endtask

    // execute with immediate grant, then shift nbits of the address
    task automatic start_txn(input logic rw, input logic [15:0] addr, input logic [7:0] din,
                             input int nbits);
        push_frame(rw, addr, din);
        M_EXECUTE = 1'b1; M_RW = rw; M_ADDR = addr; M_DIN = din; M_GRANT = 1'b1;
        tick();
        M_EXECUTE = 1'b0;
        tick();
        M_GRANT = 1'b0;
        shift_out("addr", rw, nbits);
    endtask

    // full read; split_at = bit index before which B_SPLIT is raised (8 = none)
    task automatic do_read(input logic [15:0] addr, input logic [7:0] data,
                           input int split_at, input int split_len);
        rd_q.push_back(data);
        start_txn(1'b0, addr, 8'h00, 16);
        check("rd_wait_bus", B_BUS_OUT, 0);
        B_ACK = 1'b1;
        tick();
        B_ACK = 1'b0;
        for (int i = 0; i < 8; i++) begin
            B_BUS_IN = data[i];
            if (i == split_at) begin
                B_SPLIT = 1'b1;
                repeat (split_len) tick();
                check("split_no_done", M_DONE, 0);
                B_SPLIT = 1'b0;
                tick();
            end
            tick();
        end
        B_BUS_IN = 1'b0;
        check("rd_done", M_DONE, 1);
        check("rd_err", M_ERR, 0);
        check("rd_dvalid", M_DVALID, 1);
        last_good = rd_q.pop_front();
        check("rd_dout", M_DOUT, {24'd0, last_good});
        tick();
        check("rd_idle_busy", M_BUSY, 0);
        check("rd_dvalid_pulse", M_DVALID, 0);
        check("rd_dout_hold", M_DOUT, {24'd0, last_good});
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check_all_zero("rst_hold");
        RST = 1'b0;
        tick();
        check_all_zero("rst_idle");

        // write 0A35 / C3 with delayed grant and an ignored execute while busy
        push_frame(1'b1, 16'h0A35, 8'hC3);
        M_EXECUTE = 1'b1; M_RW = 1'b1; M_ADDR = 16'h0A35; M_DIN = 8'hC3;
        tick();
        M_EXECUTE = 1'b0;
        check("wr_busy", M_BUSY, 1);
        check("wr_req", M_REQ, 1);
        check("wr_util_pre", B_UTIL, 0);
        M_EXECUTE = 1'b1; M_RW = 1'b0; M_ADDR = 16'hFFFF; M_DIN = 8'h00;
        tick();
        M_EXECUTE = 1'b0;
        check("wr_still_req", B_UTIL, 0);
        M_GRANT = 1'b1;
        tick();
        M_GRANT = 1'b0;
        shift_out("wr_addr", 1'b1, 16);
        check("wr_wait_bus", B_BUS_OUT, 0);
        tick();
        B_ACK = 1'b1;
        tick();
        B_ACK = 1'b0;
        shift_out("wr_data", 1'b1, 8);
        check("wr_wack_bus", B_BUS_OUT, 0);
        tick();
        B_ACK = 1'b1;
        tick();
        B_ACK = 1'b0;
        check("wr_done", M_DONE, 1);
        check("wr_err", M_ERR, 0);
        check("wr_dvalid", M_DVALID, 0);
        check("wr_done_req", M_REQ, 0);
        check("wr_done_util", B_UTIL, 0);
        check("wr_done_busy", M_BUSY, 1);
        tick();
        check("wr_idle_busy", M_BUSY, 0);
        check("wr_idle_done", M_DONE, 0);
        check("wr_sb_empty", bit_q.size(), 0);

        // plain read returning 5A
        do_read(16'h0004, 8'h5A, 8, 0);

        // no ack after address: abort after exactly ACK_TIMEOUT cycles
        start_txn(1'b0, 16'h1234, 8'h00, 16);
        repeat (7) tick();
        check("to_not_yet", M_DONE, 0);
        tick();
        check("to_done", M_DONE, 1);
        check("to_err", M_ERR, 1);
        check("to_dvalid", M_DVALID, 0);
        tick();
        check("to_err_hold", M_ERR, 1);
        check("to_dout_hold", M_DOUT, {24'd0, last_good});

        // read with a 5-cycle split after bit 3
        do_read(16'h00C1, 8'hA7, 4, 5);

        // reset during address bit 6, then a clean read
        start_txn(1'b1, 16'h00FF, 8'h99, 6);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check_all_zero("mid_rst");
        bit_q.delete();
        do_read(16'h8001, 8'h3C, 8, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
